// File: rtl/tx_packet_dispatcher.sv
// Parses fixed-size inband TX packets from the USB FIFO and steers payload words to the
// per-channel sample FIFOs or the command FIFO; padding and rejected packets are drained.
module tx_packet_dispatcher #(
  parameter int unsigned NUM_CHAN  = 2,
  parameter int unsigned PKT_WORDS = 256,
  parameter logic [4:0]  CMD_CHAN  = 5'h1F
) (
  input  logic                txclk,
  input  logic                reset,
  input  logic                pkt_avail,
  output logic                fifo_rdreq,
  input  logic [15:0]         fifo_q,
  input  logic [NUM_CHAN-1:0] chan_full,
  output logic [NUM_CHAN-1:0] chan_wrreq,
  input  logic                cmd_full,
  output logic                cmd_wrreq,
  output logic [15:0]         out_data,
  output logic                pkt_valid,
  output logic [4:0]          pkt_chan,
  output logic [8:0]          pkt_len,
  output logic                pkt_sob,
  output logic                pkt_eob,
  output logic [31:0]         pkt_ts,
  output logic                bad_pkt,
  output logic [7:0]          err_count
);

  localparam logic [7:0] LastIdx = 8'(PKT_WORDS - 1);
  localparam logic [8:0] MaxLen  = 9'((PKT_WORDS - 4) * 2);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrain} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          pay_left_q, pay_left_d;
  logic                run_q;
  logic [8:0]          len_q, len_d;
  logic [4:0]          chan_q, chan_d;
  logic                sob_q, sob_d, eob_q, eob_d;
  logic [15:0]         ts_lo_q, ts_lo_d;
  logic [NUM_CHAN-1:0] dst_chan_q, dst_chan_d;
  logic                dst_cmd_q, dst_cmd_d;
  logic                wr_q, wr_d;
  logic                pkt_valid_q, pkt_valid_d;
  logic                bad_q, bad_d;
  logic [7:0]          err_q, err_d;
  logic [4:0]          pkt_chan_q, pkt_chan_d;
  logic [8:0]          pkt_len_q, pkt_len_d;
  logic                pkt_sob_q, pkt_sob_d, pkt_eob_q, pkt_eob_d;
  logic [31:0]         pkt_ts_q, pkt_ts_d;

  logic                rd_req;
  logic [NUM_CHAN-1:0] chan_sel;
  logic                is_cmd, reject, dst_full;
  logic [7:0]          pay_words;

  always_comb begin
    chan_sel = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      chan_sel[i] = (chan_q == 5'(i));
    end
  end

  assign is_cmd    = (chan_q == CMD_CHAN);
  assign reject    = !(|chan_sel || is_cmd) || (len_q > MaxLen);
  assign pay_words = 8'((10'(len_q) + 10'd1) >> 1);
  assign dst_full  = |(chan_full & dst_chan_q) | (cmd_full & dst_cmd_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pay_left_d  = pay_left_q;
    len_d       = len_q;
    chan_d      = chan_q;
    sob_d       = sob_q;
    eob_d       = eob_q;
    ts_lo_d     = ts_lo_q;
    dst_chan_d  = dst_chan_q;
    dst_cmd_d   = dst_cmd_q;
    err_d       = err_q;
    pkt_chan_d  = pkt_chan_q;
    pkt_len_d   = pkt_len_q;
    pkt_sob_d   = pkt_sob_q;
    pkt_eob_d   = pkt_eob_q;
    pkt_ts_d    = pkt_ts_q;
    pkt_valid_d = 1'b0;
    bad_d       = 1'b0;
    wr_d        = 1'b0;
    rd_req      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_q && pkt_avail) begin
          rd_req  = 1'b1;
          state_d = StHdr;
        end
      end
      StHdr: begin
        // fifo_q holds header word cnt_q-1 while the header streams in.
        case (cnt_q)
          8'd1: begin
            rd_req = 1'b1;
            len_d  = fifo_q[8:0];
          end
          8'd2: begin
            rd_req = 1'b1;
            sob_d  = fifo_q[15];
            eob_d  = fifo_q[14];
            chan_d = fifo_q[4:0];
          end
          8'd3: begin
            rd_req  = 1'b1;
            ts_lo_d = fifo_q;
          end
          default: begin
            pkt_valid_d = 1'b1;
            pkt_chan_d  = chan_q;
            pkt_len_d   = len_q;
            pkt_sob_d   = sob_q;
            pkt_eob_d   = eob_q;
            pkt_ts_d    = {fifo_q, ts_lo_q};
            dst_chan_d  = chan_sel;
            dst_cmd_d   = is_cmd;
            pay_left_d  = pay_words;
            if (reject) begin
              bad_d   = 1'b1;
              state_d = StDrain;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else if (len_q == 9'd0) begin
              state_d = StDrain;
            end else begin
              state_d = StPayload;
            end
          end
        endcase
      end
      StPayload: begin
        if (!dst_full) begin
          rd_req     = 1'b1;
          wr_d       = 1'b1;
          pay_left_d = pay_left_q - 8'd1;
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
          end else if (pay_left_q == 8'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        rd_req = 1'b1;
        if (cnt_q == LastIdx) state_d = StIdle;
      end
    endcase

    if (rd_req) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pay_left_q  <= '0;
      run_q       <= 1'b0;
      len_q       <= '0;
      chan_q      <= '0;
      sob_q       <= 1'b0;
      eob_q       <= 1'b0;
      ts_lo_q     <= '0;
      dst_chan_q  <= '0;
      dst_cmd_q   <= 1'b0;
      wr_q        <= 1'b0;
      pkt_valid_q <= 1'b0;
      bad_q       <= 1'b0;
      err_q       <= '0;
      pkt_chan_q  <= '0;
      pkt_len_q   <= '0;
      pkt_sob_q   <= 1'b0;
      pkt_eob_q   <= 1'b0;
      pkt_ts_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_left_q  <= pay_left_d;
      run_q       <= 1'b1;
      len_q       <= len_d;
      chan_q      <= chan_d;
      sob_q       <= sob_d;
      eob_q       <= eob_d;
      ts_lo_q     <= ts_lo_d;
      dst_chan_q  <= dst_chan_d;
      dst_cmd_q   <= dst_cmd_d;
      wr_q        <= wr_d;
      pkt_valid_q <= pkt_valid_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
      pkt_chan_q  <= pkt_chan_d;
      pkt_len_q   <= pkt_len_d;
      pkt_sob_q   <= pkt_sob_d;
      pkt_eob_q   <= pkt_eob_d;
      pkt_ts_q    <= pkt_ts_d;
    end
  end

  // run_q keeps rdreq low while reset is held, even with pkt_avail high.
  assign fifo_rdreq = rd_req;
  assign chan_wrreq = wr_q ? dst_chan_q : '0;
  assign cmd_wrreq  = wr_q & dst_cmd_q;
  assign out_data   = wr_q ? fifo_q : 16'h0000;
  assign pkt_valid  = pkt_valid_q;
  assign bad_pkt    = bad_q;
  assign err_count  = err_q;
  assign pkt_chan   = pkt_chan_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_sob    = pkt_sob_q;
  assign pkt_eob    = pkt_eob_q;
  assign pkt_ts     = pkt_ts_q;

endmodule
